// File: rtl/adder_rr_arbiter.sv
// One unsigned W-bit adder shared by two requesters under round-robin arbitration.
// Each channel gets a registered grant, a one-cycle done pulse and a held (W+1)-bit result.
module adder_rr_arbiter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W:0]   sum0,
    output logic [W:0]   sum1,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_ptr;
    logic           r_owner;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [W:0]     r_res;
    logic           r_gnt0;
    logic           r_gnt1;
    logic           r_done0;
    logic           r_done1;
    logic [W:0]     r_sum0;
    logic [W:0]     r_sum1;
    logic           r_busy;
    logic           w_any_req;
    logic           w_win;

    function automatic logic [W:0] add_ext(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always_comb begin
        w_any_req   = req0 | req1;
        // Pointer only matters on a tie; a lone requester always wins
        w_win       = (req0 & req1) ? r_ptr : req1;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_sum0  <= '0;
            r_sum1  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                // Grant stage: capture winner and its operands
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        r_op_a  <= w_win ? a1 : a0;
                        r_op_b  <= w_win ? b1 : b0;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_busy  <= 1'b1;
                    end else begin
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                // Add stage
                S_CALC: r_res <= add_ext(r_op_a, r_op_b);
                // Completion stage: publish result, hand priority to the other channel
                S_DONE: begin
                    if (r_owner) begin
                        r_sum1  <= r_res;
                        r_done1 <= 1'b1;
                    end else begin
                        r_sum0  <= r_res;
                        r_done0 <= 1'b1;
                    end
                    r_ptr <= ~r_owner;
                end
                default: ;
            endcase
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign sum0  = r_sum0;
    assign sum1  = r_sum1;
    assign busy  = r_busy;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: inputs change and outputs are checked on the falling edge.
module tb_adder_rr_arbiter;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W:0]   sum0, sum1;

    int n_tests = 0;
    int n_fail  = 0;

    adder_rr_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .sum0(sum0), .sum1(sum1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset, then quiet idle
        repeat (2) @(negedge clk);
        chk("rst_outs", {gnt0, gnt1, done0, done1, busy}, 5'b0);
        chk("rst_sums", {sum0, sum1}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {gnt0, gnt1, done0, done1, busy}, 5'b0);
            chk("idle_sums", {sum0, sum1}, 8'h00);
        end

        // Single ch0: 3 + 5
        a0 = 3'd3; b0 = 3'd5; req0 = 1'b1;
        @(negedge clk);
        chk("c0_gnt_k", {gnt0, gnt1, busy, done0}, 4'b1010);
        req0 = 1'b0;
        @(negedge clk);
        chk("c0_gnt_k1", {gnt0, done0}, 2'b10);
        @(negedge clk);
        chk("c0_done", {gnt0, done0}, 2'b11);
        chk("c0_sum0", sum0, 4'd8);
        chk("c0_sum1", sum1, 4'd0);
        @(negedge clk);
        chk("c0_end", {gnt0, done0, busy}, 3'b000);
        chk("c0_sum0_hold", sum0, 4'd8);

        // Max operands on ch1: 7 + 7
        a1 = 3'd7; b1 = 3'd7; req1 = 1'b1;
        @(negedge clk);
        chk("c1_gnt", {gnt0, gnt1, busy}, 3'b011);
        req1 = 1'b0;
        @(negedge clk);
        chk("c1_nodone", done1, 1'b0);
        @(negedge clk);
        chk("c1_done", {done0, done1}, 2'b01);
        chk("c1_sum1", sum1, 4'b1110);
        chk("c1_sum0_hold", sum0, 4'd8);
        @(negedge clk);
        chk("c1_done_width", {done1, gnt1, busy}, 3'b000);

        // Reset, then simultaneous requests
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_sums", {sum0, sum1}, 8'h00);
        rst_n = 1'b1;
        a0 = 3'd2; b0 = 3'd1; a1 = 3'd6; b1 = 3'd7;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("sim_first", {gnt0, gnt1}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("sim_done0", {done0, done1, gnt1}, 3'b100);
        chk("sim_sum0", sum0, 4'd3);
        req0 = 1'b0;
        @(negedge clk);
        chk("sim_second", {gnt0, gnt1}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        chk("sim_done1", {done0, done1}, 2'b01);
        chk("sim_sum1", sum1, 4'd13);
        req1 = 1'b0;
        @(negedge clk);
        chk("sim_idle", {gnt0, gnt1, busy}, 3'b000);

        // Continuous contention: six ops alternating from ch0
        a0 = 3'd1; b0 = 3'd2; a1 = 3'd4; b1 = 3'd3;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("rr_overlap", {gnt0 & gnt1, done0 | done1}, 2'b00);
            @(negedge clk);
            chk("rr_done", {done0, done1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_sum", (i % 2 == 0) ? sum0 : sum1, (i % 2 == 0) ? 4'd3 : 4'd7);
            if (i == 5) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        @(negedge clk);
        chk("rr_idle", {gnt0, gnt1, busy}, 3'b000);

        // Reset mid-CALC on a ch1 op (4 + 4)
        a1 = 3'd4; b1 = 3'd4; req1 = 1'b1;
        @(negedge clk);
        chk("ab_gnt", {gnt0, gnt1}, 2'b01);
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ab_async", {gnt1, busy}, 2'b00);
        @(negedge clk);
        chk("ab_nodone", done1, 1'b0);
        chk("ab_sum1", sum1, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ab_still", {done1, sum1}, 5'b0);
        a0 = 3'd1; b0 = 3'd1; a1 = 3'd2; b1 = 3'd2;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("ab_ptr", {gnt0, gnt1}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("ab_done0", {done0, sum0}, {1'b1, 4'd2});
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
